// File: rtl/axi_lite_reg_init_master.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_reg_init_master
// Desc     : AXI4-Lite master that writes START_DATA+i to NUM_REGS registers
//            and, with SEQ_READBACK_EN defined, reads them back and verifies.
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_reg_init_master #(
    parameter int          C_M_AXI_ADDR_WIDTH = 32,
    parameter int          C_M_AXI_DATA_WIDTH = 32,
    parameter int          NUM_REGS           = 4,
    parameter logic [31:0] BASE_ADDR          = 32'h0000_0000,
    parameter logic [31:0] START_DATA         = 32'h0000_0001
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    output logic [7:0]                        err_count,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_RESP = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [IDX_W-1:0]              c_last_idx = IDX_W'(NUM_REGS - 1);
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] c_base     = C_M_AXI_ADDR_WIDTH'(BASE_ADDR);
    localparam logic [C_M_AXI_DATA_WIDTH-1:0] c_start    = C_M_AXI_DATA_WIDTH'(START_DATA);

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [IDX_W-1:0]                r_index;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   r_addr;
    logic [C_M_AXI_DATA_WIDTH-1:0]   r_data;
    logic                            r_aw_done;
    logic                            r_w_done;
    logic [7:0]                      r_err;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_wr_both;
    logic w_last;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Handshakes derived from state, not from the VALID outputs, to keep the
    // next-state logic free of combinational feedback.
    assign w_aw_hs   = (r_state == S_WR_REQ) && !r_aw_done && M_AXI_AWREADY;
    assign w_w_hs    = (r_state == S_WR_REQ) && !r_w_done && M_AXI_WREADY;
    assign w_wr_both = (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);
    assign w_last    = (r_index == c_last_idx);

    assign M_AXI_AWADDR = r_addr;
    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_WDATA  = r_data;
    assign M_AXI_WSTRB  = '1;
    assign M_AXI_ARPROT = 3'b000;
    assign err_count    = r_err;

`ifdef SEQ_READBACK_EN
    assign M_AXI_ARADDR = r_addr;
`else
    logic w_unused_rd;
    assign M_AXI_ARADDR = '0;
    assign w_unused_rd  = ^{M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID};
`endif

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_BREADY  = 1'b0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_WR_REQ;
            end
            S_WR_REQ: begin
                busy          = 1'b1;
                M_AXI_AWVALID = !r_aw_done;
                M_AXI_WVALID  = !r_w_done;
                if (w_wr_both) w_state_nxt = S_WR_RESP;
            end
            S_WR_RESP: begin
                busy         = 1'b1;
                M_AXI_BREADY = 1'b1;
                if (M_AXI_BVALID) begin
                    if (!w_last) begin
                        w_state_nxt = S_WR_REQ;
                    end else begin
`ifdef SEQ_READBACK_EN
                        w_state_nxt = S_RD_REQ;
`else
                        w_state_nxt = S_DONE;
`endif
                    end
                end
            end
`ifdef SEQ_READBACK_EN
            S_RD_REQ: begin
                busy          = 1'b1;
                M_AXI_ARVALID = 1'b1;
                if (M_AXI_ARREADY) w_state_nxt = S_RD_RESP;
            end
            S_RD_RESP: begin
                busy         = 1'b1;
                M_AXI_RREADY = 1'b1;
                if (M_AXI_RVALID) w_state_nxt = w_last ? S_DONE : S_RD_REQ;
            end
`endif
            S_DONE: begin
                done = 1'b1;
                if (start) w_state_nxt = S_WR_REQ;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_index   <= '0;
            r_addr    <= '0;
            r_data    <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_err     <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_index   <= '0;
                        r_addr    <= c_base;
                        r_data    <= c_start;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_err     <= 8'd0;
                    end
                end
                S_WR_REQ: begin
                    if (w_aw_hs) r_aw_done <= 1'b1;
                    if (w_w_hs)  r_w_done  <= 1'b1;
                end
                S_WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        if (M_AXI_BRESP != 2'b00) r_err <= sat_inc(r_err);
                        // Rewind to the first register so the read pass starts there
                        if (w_last) begin
                            r_index <= '0;
                            r_addr  <= c_base;
                            r_data  <= c_start;
                        end else begin
                            r_index <= r_index + 1'b1;
                            r_addr  <= r_addr + C_M_AXI_ADDR_WIDTH'(4);
                            r_data  <= r_data + C_M_AXI_DATA_WIDTH'(1);
                        end
                    end
                end
`ifdef SEQ_READBACK_EN
                S_RD_RESP: begin
                    if (M_AXI_RVALID) begin
                        // A bad response and a bad value on one beat count once
                        if ((M_AXI_RRESP != 2'b00) || (M_AXI_RDATA != r_data)) begin
                            r_err <= sat_inc(r_err);
                        end
                        if (!w_last) begin
                            r_index <= r_index + 1'b1;
                            r_addr  <= r_addr + C_M_AXI_ADDR_WIDTH'(4);
                            r_data  <= r_data + C_M_AXI_DATA_WIDTH'(1);
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/axi_lite_reg_init_master.md
# axi_lite_reg_init_master

AXI4-Lite master that, on a start pulse, programs a contiguous bank of 32-bit registers in the downstream `register_block` slave with an incrementing data pattern, then optionally reads every register back and checks it. Sits directly upstream of the register block's S00_AXI port and serves as the power-on initializer and built-in self-test for the register bank. Reports busy, done and an error count to control logic.

## Interface
- C_M_AXI_ADDR_WIDTH, 32, address width of the master port.
- C_M_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- NUM_REGS, 4, number of registers written and read (1..256).
- BASE_ADDR, 32'h0000_0000, byte address of the first register; word-aligned.
- START_DATA, 32'h0000_0001, data written to the first register; register i receives START_DATA+i.

Ports:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  synchronous, active-high reset.
- start  in  1  begin a sequence; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until DONE is reached.
- done  out  1  high in DONE, held until the next accepted start or reset.
- err_count  out  8  saturating count of failed responses and compares.
- M_AXI_AWADDR / AWPROT / AWVALID / AWREADY  out/out/out/in  ADDR/3/1/1  write address channel; AWPROT=3'b000.
- M_AXI_WDATA / WSTRB / WVALID / WREADY  out/out/out/in  32/4/1/1  write data; WSTRB=4'hF.
- M_AXI_BRESP / BVALID / BREADY  in/in/out  2/1/1  write response.
- M_AXI_ARADDR / ARPROT / ARVALID / ARREADY  out/out/out/in  ADDR/3/1/1  read address; ARPROT=3'b000.
- M_AXI_RDATA / RRESP / RVALID / RREADY  in/in/in/out  32/2/1/1  read data.

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE: start=1 → clear index and err_count, go WR_REQ; done drops.
- WR_REQ: AWVALID and WVALID asserted together, addr = BASE_ADDR + 4*index, data = START_DATA + index (mod 2^32). Each valid drops independently on its own handshake; when both have completed → WR_RESP.
- WR_RESP: BREADY=1. On BVALID: BRESP≠OKAY increments err_count. If index = NUM_REGS-1 → reset index, go RD_REQ; else index+1, go WR_REQ.
- RD_REQ: ARVALID with addr = BASE_ADDR + 4*index; on ARREADY → RD_RESP.
- RD_RESP: RREADY=1. On RVALID: RRESP≠OKAY or RDATA ≠ START_DATA+index increments err_count (once per beat, even if both fail). Last index → DONE, else index+1, RD_REQ.
- DONE: done=1, busy=0; start=1 → restart as from IDLE.
- Exactly one outstanding transaction at a time; no AXI IDs, no bursts.
- err_count saturates at 8'hFF.
- start while busy is ignored.

## Timing
- Reset values: all VALID/READY outputs 0, AWADDR/ARADDR/WDATA 0, busy 0, done 0, err_count 0, state IDLE.
- ARESET mid-sequence: all outputs take reset values at the next edge regardless of pending handshakes; the slave is expected to be reset alongside.
- start accepted at edge N → AWVALID/WVALID high after edge N.
- VALID, once high, holds with stable ADDR/DATA until its handshake edge (AXI rule).
- Zero-wait slave: per write 2 cycles (REQ, RESP); per read 2 cycles; total 4*NUM_REGS cycles from start to done, plus 1 entering DONE.
- AWREADY and WREADY in different cycles: each channel completes separately; WR_RESP entered the edge after the later one.
- BREADY/RREADY asserted only in their RESP state; no response accepted in the same cycle as its request.

## Configuration
- SEQ_READBACK_EN defined: full write-then-read-verify sequence as above.
- Not defined: RD_REQ/RD_RESP removed; after the last write response → DONE; ARVALID and RREADY tied 0; err_count counts only BRESP errors; total latency 2*NUM_REGS+1 cycles.

## Test plan
- Defaults, zero-wait register_block, start pulse → writes 1,2,3,4 to 0x0,0x4,0x8,0xC; readback matches; done=1, err_count=0 after 17 cycles.
- Slave returns BRESP=SLVERR on address 0x8 → err_count=1, sequence still completes, done=1.
- Slave corrupts RDATA at 0x4 to 0xDEAD_BEEF → err_count=1; same beat with RRESP=SLVERR still counts 1.
- Random AWREADY/WREADY/ARREADY stalls (0-5 cycles, independent) → addresses/data stable while VALID high, same final result as first test.
- ARESET asserted during RD_RESP of index 2 → next edge all outputs reset; new start runs full sequence cleanly.
- START_DATA=32'hFFFF_FFFF, NUM_REGS=2 → writes 0xFFFF_FFFF then 0x0000_0000; without SEQ_READBACK_EN: ARVALID never high, done after 5 cycles.
